// File: rtl/tlb_pkg.sv
// Shared TLB definitions: entry layout, exception and segment encodings, and
// the ExcCode mapping the pipeline uses when it raises a TLB exception.
package tlb_pkg;
    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    localparam logic [1:0] TLB_EX_NONE    = 2'd0;
    localparam logic [1:0] TLB_EX_REFILL  = 2'd1;
    localparam logic [1:0] TLB_EX_INVALID = 2'd2;
    localparam logic [1:0] TLB_EX_MOD     = 2'd3;

    localparam logic [2:0] SEG_KSEG0  = 3'b100;
    localparam logic [2:0] SEG_KSEG1  = 3'b101;
    localparam logic [2:0] C_UNCACHED = 3'd2;

    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic [1:0]  ex;
    } xlate_t;

    // Refill and invalid share an ExcCode; only the access direction splits them.
    function automatic logic [4:0] tlb_exccode(input logic [1:0] ex, input logic store);
        if (ex == TLB_EX_MOD) return EXC_MOD;
        return store ? EXC_TLBS : EXC_TLBL;
    endfunction
endpackage

// File: rtl/tlb_match.sv
// Fully associative compare of one VPN2/ASID key against every entry;
// reports a hit and the lowest matching index (0 on a miss).
module tlb_match
    import tlb_pkg::*;
(
    input  logic [TLBNUM*19-1:0] vpn2_all,
    input  logic [TLBNUM*8-1:0]  asid_all,
    input  logic [TLBNUM-1:0]    g_all,
    input  logic [18:0]          vpn2,
    input  logic [7:0]           asid,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);
    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan downward so the lowest matching entry is the last one written.
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (vpn2_all[i*19 +: 19] == vpn2 && (g_all[i] || asid_all[i*8 +: 8] == asid)) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/tlb_unit.sv
// 16-entry MIPS32 joint TLB: TLBWI/TLBR/TLBP for CP0 plus two registered
// translation ports (s0 fetch, s1 data) with kseg0/kseg1 bypass.
module tlb_unit
    import tlb_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_tlbwi,
    input  logic        inst_tlbr,
    input  logic        inst_tlbp,
    input  logic [3:0]  cp0_to_tlb_index,
    input  logic [18:0] cp0_to_tlb_vpn2,
    input  logic [7:0]  cp0_to_tlb_asid,
    input  logic [19:0] cp0_to_tlb_pfn0,
    input  logic [2:0]  cp0_to_tlb_c0,
    input  logic        cp0_to_tlb_d0,
    input  logic        cp0_to_tlb_v0,
    input  logic        cp0_to_tlb_g0,
    input  logic [19:0] cp0_to_tlb_pfn1,
    input  logic [2:0]  cp0_to_tlb_c1,
    input  logic        cp0_to_tlb_d1,
    input  logic        cp0_to_tlb_v1,
    input  logic        cp0_to_tlb_g1,
    output logic [18:0] tlb_to_cp0_vpn2,
    output logic [7:0]  tlb_to_cp0_asid,
    output logic [19:0] tlb_to_cp0_pfn0,
    output logic [2:0]  tlb_to_cp0_c0,
    output logic        tlb_to_cp0_d0,
    output logic        tlb_to_cp0_v0,
    output logic        tlb_to_cp0_g0,
    output logic [19:0] tlb_to_cp0_pfn1,
    output logic [2:0]  tlb_to_cp0_c1,
    output logic        tlb_to_cp0_d1,
    output logic        tlb_to_cp0_v1,
    output logic        tlb_to_cp0_g1,
    output logic        tlb_to_cp0_found,
    output logic [3:0]  tlb_to_cp0_index,
    input  logic        s0_req,
    input  logic [31:0] s0_vaddr,
    output logic        s0_rvalid,
    output logic [31:0] s0_paddr,
    output logic        s0_uncached,
    output logic [1:0]  s0_ex,
    input  logic        s1_req,
    input  logic [31:0] s1_vaddr,
    input  logic        s1_store,
    output logic        s1_rvalid,
    output logic [31:0] s1_paddr,
    output logic        s1_uncached,
    output logic [1:0]  s1_ex
);
    tlb_entry_t [TLBNUM-1:0] entry_q, entry_d;
    logic [TLBNUM*19-1:0] vpn2_all;
    logic [TLBNUM*8-1:0]  asid_all;
    logic [TLBNUM-1:0]    g_all;

    logic             s0_found, s1_found, p_found;
    logic [IDX_W-1:0] s0_idx, s1_idx, p_idx;
    tlb_entry_t       s0_e, s1_e, rd_e;
    xlate_t           s0_xl, s1_xl, s0_res_q, s0_res_d, s1_res_q, s1_res_d;
    logic             s0_rvalid_q, s0_rvalid_d, s1_rvalid_q, s1_rvalid_d;

    function automatic xlate_t translate(input logic [31:0] vaddr, input logic found,
                                         input logic [19:0] pfn, input logic [2:0] c,
                                         input logic d, input logic v, input logic store);
        xlate_t r;
        r = '0;
        if (vaddr[31:29] == SEG_KSEG0) begin
            r.paddr = {3'b000, vaddr[28:0]};
        end else if (vaddr[31:29] == SEG_KSEG1) begin
            r.paddr    = {3'b000, vaddr[28:0]};
            r.uncached = 1'b1;
        end else if (!found) begin
            r.ex = TLB_EX_REFILL;
        end else if (!v) begin
            r.ex = TLB_EX_INVALID;
        end else if (store && !d) begin
            r.ex = TLB_EX_MOD;
        end else begin
            r.paddr    = {pfn, vaddr[11:0]};
            r.uncached = (c == C_UNCACHED);
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            vpn2_all[i*19 +: 19] = entry_q[i].vpn2;
            asid_all[i*8 +: 8]   = entry_q[i].asid;
            g_all[i]             = entry_q[i].g;
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (inst_tlbwi) begin
            entry_d[cp0_to_tlb_index] = '{vpn2: cp0_to_tlb_vpn2, asid: cp0_to_tlb_asid,
                                          g: cp0_to_tlb_g0 & cp0_to_tlb_g1,
                                          pfn0: cp0_to_tlb_pfn0, c0: cp0_to_tlb_c0,
                                          d0: cp0_to_tlb_d0, v0: cp0_to_tlb_v0,
                                          pfn1: cp0_to_tlb_pfn1, c1: cp0_to_tlb_c1,
                                          d1: cp0_to_tlb_d1, v1: cp0_to_tlb_v1};
        end
    end

    tlb_match u_match_s0 (.vpn2_all(vpn2_all), .asid_all(asid_all), .g_all(g_all),
                          .vpn2(s0_vaddr[31:13]), .asid(cp0_to_tlb_asid),
                          .found(s0_found), .index(s0_idx));
    tlb_match u_match_s1 (.vpn2_all(vpn2_all), .asid_all(asid_all), .g_all(g_all),
                          .vpn2(s1_vaddr[31:13]), .asid(cp0_to_tlb_asid),
                          .found(s1_found), .index(s1_idx));
    tlb_match u_match_p  (.vpn2_all(vpn2_all), .asid_all(asid_all), .g_all(g_all),
                          .vpn2(cp0_to_tlb_vpn2), .asid(cp0_to_tlb_asid),
                          .found(p_found), .index(p_idx));

    // Lookups read entry_q, so a same-cycle TLBWI is only seen a cycle later.
    always_comb begin
        s0_e  = entry_q[s0_idx];
        s1_e  = entry_q[s1_idx];
        s0_xl = translate(s0_vaddr, s0_found, s0_vaddr[12] ? s0_e.pfn1 : s0_e.pfn0,
                          s0_vaddr[12] ? s0_e.c1 : s0_e.c0, s0_vaddr[12] ? s0_e.d1 : s0_e.d0,
                          s0_vaddr[12] ? s0_e.v1 : s0_e.v0, 1'b0);
        s1_xl = translate(s1_vaddr, s1_found, s1_vaddr[12] ? s1_e.pfn1 : s1_e.pfn0,
                          s1_vaddr[12] ? s1_e.c1 : s1_e.c0, s1_vaddr[12] ? s1_e.d1 : s1_e.d0,
                          s1_vaddr[12] ? s1_e.v1 : s1_e.v0, s1_store);
        s0_rvalid_d = s0_req;
        s1_rvalid_d = s1_req;
        s0_res_d    = s0_req ? s0_xl : s0_res_q;
        s1_res_d    = s1_req ? s1_xl : s1_res_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            entry_q     <= '0;
            s0_rvalid_q <= 1'b0;
            s1_rvalid_q <= 1'b0;
            s0_res_q    <= '0;
            s1_res_q    <= '0;
        end else begin
            entry_q     <= entry_d;
            s0_rvalid_q <= s0_rvalid_d;
            s1_rvalid_q <= s1_rvalid_d;
            s0_res_q    <= s0_res_d;
            s1_res_q    <= s1_res_d;
        end
    end

    assign s0_rvalid   = s0_rvalid_q;
    assign s0_paddr    = s0_res_q.paddr;
    assign s0_uncached = s0_res_q.uncached;
    assign s0_ex       = s0_res_q.ex;
    assign s1_rvalid   = s1_rvalid_q;
    assign s1_paddr    = s1_res_q.paddr;
    assign s1_uncached = s1_res_q.uncached;
    assign s1_ex       = s1_res_q.ex;

    // Read/probe outputs are forced to zero when not requested to stay X-free.
    assign rd_e             = inst_tlbr ? entry_q[cp0_to_tlb_index] : '0;
    assign tlb_to_cp0_vpn2  = rd_e.vpn2;
    assign tlb_to_cp0_asid  = rd_e.asid;
    assign tlb_to_cp0_pfn0  = rd_e.pfn0;
    assign tlb_to_cp0_c0    = rd_e.c0;
    assign tlb_to_cp0_d0    = rd_e.d0;
    assign tlb_to_cp0_v0    = rd_e.v0;
    assign tlb_to_cp0_g0    = rd_e.g;
    assign tlb_to_cp0_pfn1  = rd_e.pfn1;
    assign tlb_to_cp0_c1    = rd_e.c1;
    assign tlb_to_cp0_d1    = rd_e.d1;
    assign tlb_to_cp0_v1    = rd_e.v1;
    assign tlb_to_cp0_g1    = rd_e.g;
    assign tlb_to_cp0_found = inst_tlbp & p_found;
    assign tlb_to_cp0_index = inst_tlbp ? p_idx : '0;
endmodule
